// File: rtl/iir_coe_loader.sv
// iir_coe_loader
//
// Streams six-word biquad coefficient sets from a synchronous coefficient ROM
// to a bank of NUM_BANDS filters over a shared serial load port. Any band
// whose gain code changes (or every band on load_all or after reset) gets a
// new frame. Bands are served lowest index first.
//
// Frame layout on the outputs, one row per cycle:
//   F0..F6 : coe_en[b] high (7 beats)
//   F0..F5 : rom_rd high, rom_addr = {b, g, k}
//   F1     : coe = 0 (dummy slot)
//   F2..F7 : coe = ROM words 0..5 (b0 b1 b2 a0 a1 a2)
//   F7..   : GAP idle cycles, counting F7 as the first
//   F8     : frame_done pulse
//
// Ports:
//   clk_40k    : sample/data clock
//   rst        : asynchronous active-low reset
//   gain_sel   : per-band gain code, band b at [b*GAIN_W +: GAIN_W]
//   load_all   : one-cycle pulse, reload every band
//   rom_addr   : {band, clamped gain, word index}
//   rom_rd     : ROM read enable, data valid the following cycle
//   rom_data   : ROM word
//   coe        : Q2.15 coefficient bus shared by all bands
//   coe_en     : per-band frame enable, one-hot or zero
//   busy       : frame in progress or band pending
//   frame_done : receiver latches its new set at the end of this cycle

module iir_coe_loader #(
    parameter int unsigned NUM_BANDS = 10,
    parameter int unsigned BAND_W    = 4,
    parameter int unsigned GAIN_W    = 5,
    parameter int unsigned GAIN_MAX  = 24,
    parameter int unsigned GAP       = 2
) (
    input  logic                        clk_40k,
    input  logic                        rst,
    input  logic [NUM_BANDS*GAIN_W-1:0] gain_sel,
    input  logic                        load_all,
    output logic [BAND_W+GAIN_W+2:0]    rom_addr,
    output logic                        rom_rd,
    input  logic [16:0]                 rom_data,
    output logic [16:0]                 coe,
    output logic [NUM_BANDS-1:0]        coe_en,
    output logic                        busy,
    output logic                        frame_done
);

    // The FSM runs one cycle ahead of the registered outputs: internal count
    // value p produces the output row of frame cycle Fp on the next cycle.
    localparam int unsigned CntW    = $clog2(GAP + 8);
    localparam int unsigned LastCnt = 6 + GAP;

    typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [BAND_W-1:0]      band_q, band_d;
    logic [GAIN_W-1:0]      gain_q, gain_d;
    logic [NUM_BANDS-1:0]   pending_q, pending_d;
    logic [GAIN_W-1:0]      shadow_q [NUM_BANDS];
    logic [GAIN_W-1:0]      shadow_d [NUM_BANDS];
    logic [GAIN_W-1:0]      gain_clamped [NUM_BANDS];

    logic                   rd_dly_q;
    logic                   last_en_q;
    logic                   start;
    logic                   pick_valid;
    logic [BAND_W-1:0]      pick_band;
    logic [GAIN_W-1:0]      pick_gain;

    logic [BAND_W+GAIN_W+2:0] rom_addr_d;
    logic                     rom_rd_d;
    logic [16:0]              coe_d;
    logic [NUM_BANDS-1:0]     coe_en_d;
    logic                     busy_d;

    function automatic logic [GAIN_W-1:0] clamp_gain(input logic [GAIN_W-1:0] g);
        if (32'(g) > GAIN_MAX) begin
            return GAIN_W'(GAIN_MAX);
        end
        return g;
    endfunction

    always_comb begin
        for (int b = 0; b < NUM_BANDS; b++) begin
            gain_clamped[b] = clamp_gain(gain_sel[b*GAIN_W +: GAIN_W]);
        end
    end

    // Lowest-index pending band wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_band  = '0;
        pick_gain  = '0;
        for (int i = NUM_BANDS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                pick_valid = 1'b1;
                pick_band  = BAND_W'(i);
                pick_gain  = gain_clamped[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        band_d  = band_q;
        gain_d  = gain_q;
        start   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    start = 1'b1;
                end
            end
            StSend: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(6)) begin
                    state_d = StGap;
                end
            end
            StGap: begin
                if (cnt_q == CntW'(LastCnt)) begin
                    // Chain straight into the next frame so the period stays 7+GAP.
                    if (pick_valid) begin
                        start = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (start) begin
            state_d = StSend;
            cnt_d   = '0;
            band_d  = pick_band;
            gain_d  = pick_gain;
        end
    end

    // Comparing against the next shadow keeps the band being started from
    // re-pending on its own latch, while a later change re-pends it.
    always_comb begin
        for (int b = 0; b < NUM_BANDS; b++) begin
            logic clr;
            clr          = start && (pick_band == BAND_W'(b));
            shadow_d[b]  = clr ? gain_clamped[b] : shadow_q[b];
            pending_d[b] = (pending_q[b] & ~clr)
                         | (gain_clamped[b] != shadow_d[b])
                         | load_all;
        end
    end

    always_comb begin
        for (int b = 0; b < NUM_BANDS; b++) begin
            coe_en_d[b] = (state_q == StSend) && (band_q == BAND_W'(b));
        end
        rom_rd_d   = (state_q == StSend) && (cnt_q <= CntW'(5));
        rom_addr_d = rom_rd_d ? {band_q, gain_q, cnt_q[2:0]} : rom_addr;
        if (rd_dly_q) begin
            coe_d = rom_data;
        end else if ((state_q == StSend) && (cnt_q == CntW'(1))) begin
            coe_d = '0;
        end else begin
            coe_d = coe;
        end
        busy_d = (state_d != StIdle) || (state_q != StIdle);
    end

    always_ff @(posedge clk_40k or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            band_q     <= '0;
            gain_q     <= '0;
            pending_q  <= '1;
            rd_dly_q   <= 1'b0;
            last_en_q  <= 1'b0;
            rom_addr   <= '0;
            rom_rd     <= 1'b0;
            coe        <= '0;
            coe_en     <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            for (int b = 0; b < NUM_BANDS; b++) begin
                shadow_q[b] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            band_q     <= band_d;
            gain_q     <= gain_d;
            pending_q  <= pending_d;
            rd_dly_q   <= rom_rd;
            // High during F7, so frame_done lands in F8.
            last_en_q  <= (state_q == StGap) && (cnt_q == CntW'(7));
            rom_addr   <= rom_addr_d;
            rom_rd     <= rom_rd_d;
            coe        <= coe_d;
            coe_en     <= coe_en_d;
            busy       <= busy_d;
            frame_done <= last_en_q;
            for (int b = 0; b < NUM_BANDS; b++) begin
                shadow_q[b] <= shadow_d[b];
            end
        end
    end

endmodule
